// File: rtl/backend_pkg.sv
// rtl/backend_pkg.sv - shared backend constants and arbiter state type
package backend_pkg;

  localparam int NMODULES = 4;
  localparam int LENGTH   = 128;
  localparam int CMD_LEN  = 32;
  localparam int CNT_W    = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational cyclic first-one finder starting at ptr_i
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  always_comb begin
    dbl     = {req_i, req_i} >> ptr_i;
    rot     = dbl[N-1:0];
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    // Walk from the far end so the nearest request to ptr_i wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        sum     = {1'b0, ptr_i} + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) begin
          sum = sum - (IW + 1)'(N);
        end
        idx_o = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// rtl/rx_stream_arbiter.sv - round-robin arbiter of rx fifos onto one registered output stage
// Optional per-module word / drop counters are built only when ARB_COUNTERS_EN is defined.
module rx_stream_arbiter
  import backend_pkg::*;
#(
  parameter int NMODULES  = backend_pkg::NMODULES,
  parameter int LENGTH    = backend_pkg::LENGTH,
  parameter int MAX_BURST = 8,
  parameter int SRC_W     = $clog2(NMODULES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NMODULES-1:0]          en,
  input  logic [NMODULES-1:0]          in_valid,
  input  logic [NMODULES*LENGTH-1:0]   in_data,
  output logic [NMODULES-1:0]          in_ready,
  output logic                         out_valid,
  output logic [LENGTH-1:0]            out_data,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         out_ready,
  output logic [NMODULES*CNT_W-1:0]    cnt_words,
  output logic [CNT_W-1:0]             cnt_drops
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(NMODULES - 1);

  arb_state_t state_q, state_d;
  logic [SRC_W-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              out_valid_q;
  logic [LENGTH-1:0] out_data_q;
  logic [SRC_W-1:0]  out_src_q;

  logic              sel_found;
  logic [SRC_W-1:0]  sel_idx;
  logic [NMODULES-1:0] grant_oh;
  logic              room;
  logic              accept;
  logic [LENGTH-1:0] in_words [NMODULES];

  for (genvar i = 0; i < NMODULES; i++) begin : g_unpack
    assign in_words[i] = in_data[i*LENGTH +: LENGTH];
  end

  rr_select #(
    .N  (NMODULES),
    .IW (SRC_W)
  ) u_rr_select (
    .req_i   (en & in_valid),
    .ptr_i   (ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  // Disabled modules are drained unconditionally; nothing pops while rst is high.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = (state_q == GRANT);
    room              = ~out_valid_q | out_ready;
    accept            = ~rst & (state_q == GRANT) & en[grant_q] & in_valid[grant_q] & room;
    in_ready          = rst ? '0 : ((~en & in_valid) | (grant_oh & en & {NMODULES{room}}));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = GRANT;
          grant_d = sel_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          burst_d = burst_q + BW'(1);
        end
        if (!in_valid[grant_q] || !en[grant_q] || (accept && (burst_q == BURST_LAST))) begin
          state_d = IDLE;
          ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + SRC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      // A same-cycle pop refills the stage, so out_valid stays high through a transfer.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_words[grant_q];
        out_src_q   <= grant_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARB_COUNTERS_EN
  logic [CNT_W-1:0] words_q [NMODULES];
  logic [CNT_W-1:0] drops_q;
  logic [CNT_W-1:0] drop_inc;

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NMODULES; i++) begin
      drop_inc = drop_inc + CNT_W'(~en[i] & in_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drops_q <= '0;
      for (int i = 0; i < NMODULES; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      drops_q <= drops_q + drop_inc;
      if (accept) begin
        words_q[grant_q] <= words_q[grant_q] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NMODULES; i++) begin : g_cnt
    assign cnt_words[i*CNT_W +: CNT_W] = words_q[i];
  end
  assign cnt_drops = drops_q;
`else
  assign cnt_words = '0;
  assign cnt_drops = '0;
`endif

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// tb/tb_rx_stream_arbiter.sv - randomized bench with fifo models and an output scoreboard
module tb_rx_stream_arbiter;

  localparam int N   = 4;
  localparam int LEN = 128;
  localparam int MB  = 8;
  localparam int SW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     en, in_valid, in_ready;
  logic [N*LEN-1:0] in_data;
  logic             out_valid, out_ready;
  logic [LEN-1:0]   out_data;
  logic [SW-1:0]    out_src;
  logic [N*32-1:0]  cnt_words;
  logic [31:0]      cnt_drops;

  always #5 clk = ~clk;

  rx_stream_arbiter #(
    .NMODULES  (N),
    .LENGTH    (LEN),
    .MAX_BURST (MB),
    .SRC_W     (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .cnt_words (cnt_words),
    .cnt_drops (cnt_drops)
  );

  typedef struct packed {
    logic [SW-1:0]  src;
    logic [LEN-1:0] data;
  } word_t;

  logic [LEN-1:0] fifo_q [N][$];
  word_t          exp_q[$];
  int             acc_cyc[$], acc_log[$], xfer_cyc[$], xfer_log[$];
  int             pops [N];
  int             words_model [N];
  int             drops_model;
  int             passed, total, cyc;
  int             acc_src;
  logic           stall_pend;

  function automatic int exp_cnt(int v);
`ifdef ARB_COUNTERS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [LEN-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_log.delete(); xfer_cyc.delete(); xfer_log.delete();
  endtask

  // One clock: drive fifo heads, sample mid-cycle, score, then pop the model fifos.
  task automatic tick();
    word_t w;
    int    n_acc;
    for (int i = 0; i < N; i++) begin
      in_valid[i]          = fifo_q[i].size() > 0;
      in_data[i*LEN +: LEN] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : '0;
    end
    #1;
    acc_src = -1;
    n_acc   = 0;
    if (rst) begin
      total++;
      if (in_ready !== '0) $display("FAIL rst_in_ready: got %b want 0", in_ready);
      else passed++;
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL hold: got out_valid=%b with empty scoreboard want held word", out_valid);
        else if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_src !== exp_q[0].src)
          $display("FAIL hold: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                   out_valid, out_src, out_data, exp_q[0].src, exp_q[0].data);
        else passed++;
      end
      for (int i = 0; i < N; i++) begin
        if (!en[i]) begin
          total++;
          if (in_ready[i] !== in_valid[i]) $display("FAIL drain_ready[%0d]: got %b want %b", i, in_ready[i], in_valid[i]);
          else passed++;
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL spurious_out: got src=%0d data=%h want no transfer", out_src, out_data);
        else begin
          w = exp_q.pop_front();
          if (out_data !== w.data || out_src !== w.src)
            $display("FAIL out_word: got src=%0d data=%h want src=%0d data=%h", out_src, out_data, w.src, w.data);
          else passed++;
        end
        xfer_cyc.push_back(cyc); xfer_log.push_back(int'(out_src));
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          pops[i]++;
          if (!en[i]) drops_model++;
          else begin
            n_acc++;
            acc_src = i;
            w.src = SW'(i); w.data = fifo_q[i][0];
            exp_q.push_back(w);
            words_model[i]++;
            acc_cyc.push_back(cyc); acc_log.push_back(i);
          end
        end
      end
      total++;
      if (n_acc > 1) $display("FAIL one_accept: got %0d accepts want <=1", n_acc);
      else passed++;
      stall_pend = out_valid && !out_ready;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i]) void'(fifo_q[i].pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0; en = '1;
    for (int i = 0; i < N; i++) begin
      fifo_q[i].delete(); pops[i] = 0; words_model[i] = 0;
    end
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    drops_model = 0;
    clear_logs();
  endtask

  task automatic check_counters(string tag);
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt_words[i*32 +: 32] !== 32'(exp_cnt(words_model[i])))
        $display("FAIL %s_cnt_words[%0d]: got %0d want %0d", tag, i, cnt_words[i*32 +: 32], exp_cnt(words_model[i]));
      else passed++;
    end
    total++;
    if (cnt_drops !== 32'(exp_cnt(drops_model)))
      $display("FAIL %s_cnt_drops: got %0d want %0d", tag, cnt_drops, exp_cnt(drops_model));
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0)
      $display("FAIL reset_out: got v=%b src=%0d data=%h want 0/0/0", out_valid, out_src, out_data);
    else passed++;
    check_counters("reset");
    rst = 1'b1;
    for (int k = 0; k < 3; k++) fifo_q[0].push_back(rand_word());
    tick(); tick();
    total++;
    if (fifo_q[0].size() != 3) $display("FAIL reset_no_pop: got %0d words want 3", fifo_q[0].size());
    else passed++;
  endtask

  task automatic test_single_module();
    int t0;
    do_reset();
    for (int k = 0; k < 5; k++) fifo_q[2].push_back(rand_word());
    out_ready = 1'b1;
    t0 = cyc;
    repeat (10) tick();
    total++;
    if (xfer_log.size() != 5) $display("FAIL single_count: got %0d want 5", xfer_log.size());
    else passed++;
    for (int k = 0; k < xfer_log.size() && k < 5; k++) begin
      total++;
      if (xfer_log[k] != 2 || xfer_cyc[k] != t0 + 2 + k)
        $display("FAIL single_xfer[%0d]: got src=%0d cyc=%0d want src=2 cyc=%0d", k, xfer_log[k], xfer_cyc[k], t0 + 2 + k);
      else passed++;
    end
    check_counters("single");
  endtask

  task automatic test_round_robin();
    int t0, e_cyc;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 40; k++) fifo_q[i].push_back(rand_word());
    out_ready = 1'b1;
    t0 = cyc;
    repeat (80) tick();
    total++;
    if (acc_log.size() < 64) $display("FAIL rr_count: got %0d accepts want >=64", acc_log.size());
    else begin
      passed++;
      for (int k = 0; k < 64; k++) begin
        e_cyc = t0 + (k / MB) * (MB + 1) + 1 + (k % MB);
        total++;
        if (acc_log[k] != (k / MB) % N || acc_cyc[k] != e_cyc)
          $display("FAIL rr_seq[%0d]: got src=%0d cyc=%0d want src=%0d cyc=%0d", k, acc_log[k], acc_cyc[k], (k / MB) % N, e_cyc);
        else passed++;
      end
    end
    check_counters("rr");
  endtask

  task automatic test_backpressure();
    int             p0;
    logic [LEN-1:0] first;
    do_reset();
    for (int k = 0; k < 20; k++) fifo_q[0].push_back(rand_word());
    first = fifo_q[0][0];
    tick();
    p0 = pops[0];
    repeat (10) tick();
    total++;
    if (pops[0] - p0 != 1 || out_valid !== 1'b1 || out_data !== first || out_src !== '0)
      $display("FAIL bp_start: got pops=%0d v=%b src=%0d data=%h want pops=1 v=1 src=0 data=%h",
               pops[0] - p0, out_valid, out_src, out_data, first);
    else passed++;
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    p0 = pops[0];
    repeat (10) tick();
    total++;
    if (pops[0] - p0 != 0) $display("FAIL bp_mid_pops: got %0d want 0", pops[0] - p0);
    else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && (fifo_q[0].size() > 0 || exp_q.size() > 0); k++) tick();
    total++;
    if (xfer_log.size() != 20 || exp_q.size() != 0)
      $display("FAIL bp_delivered: got %0d pending=%0d want 20 pending=0", xfer_log.size(), exp_q.size());
    else passed++;
  endtask

  task automatic test_disabled_drain();
    do_reset();
    en = 4'b1101;
    for (int k = 0; k < 20; k++) fifo_q[1].push_back(rand_word());
    out_ready = 1'b1;
    repeat (20) tick();
    total++;
    if (fifo_q[1].size() != 0 || xfer_log.size() != 0 || drops_model != 20)
      $display("FAIL drain: got left=%0d xfers=%0d drops=%0d want 0/0/20", fifo_q[1].size(), xfer_log.size(), drops_model);
    else passed++;
    check_counters("drain");
    en = '1;
  endtask

  task automatic test_reset_mid_burst();
    int s2, s3;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      fifo_q[2].push_back(rand_word()); fifo_q[3].push_back(rand_word());
    end
    out_ready = 1'b1;
    repeat (13) tick();
    total++;
    if (acc_log.size() != 11 || acc_log[acc_log.size()-1] != 3)
      $display("FAIL rmb_setup: got %0d accepts want 11 ending on module 3", acc_log.size());
    else passed++;
    s2 = fifo_q[2].size(); s3 = fifo_q[3].size();
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL rmb_out_valid: got %b want 0", out_valid);
    else passed++;
    rst = 1'b0;
    exp_q.delete();
    clear_logs();
    total++;
    if (fifo_q[2].size() != s2 || fifo_q[3].size() != s3)
      $display("FAIL rmb_fifo: got %0d/%0d want %0d/%0d", fifo_q[2].size(), fifo_q[3].size(), s2, s3);
    else passed++;
    tick(); tick();
    total++;
    if (acc_log.size() != 1 || acc_log[0] != 2)
      $display("FAIL rmb_restart: got %0d accepts first=%0d want 1 from module 2",
               acc_log.size(), acc_log.size() > 0 ? acc_log[0] : -1);
    else passed++;
  endtask

  task automatic test_random();
    int run, last_src, last_cyc;
    do_reset();
    run = 0; last_src = -1; last_cyc = -10;
    for (int t = 0; t < 800; t++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, N-1)] = $urandom_range(0, 1) != 0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) < 3 && fifo_q[i].size() < 30) fifo_q[i].push_back(rand_word());
      tick();
      if (acc_src >= 0) begin
        run = (acc_src == last_src && acc_cyc[acc_cyc.size()-1] == last_cyc + 1) ? run + 1 : 1;
        last_src = acc_src; last_cyc = acc_cyc[acc_cyc.size()-1];
        total++;
        if (run > MB) $display("FAIL burst_len: got %0d want <=%0d", run, MB);
        else passed++;
      end
    end
    en = '1; out_ready = 1'b1;
    for (int k = 0; k < 400 && (exp_q.size() > 0 || fifo_q[0].size() + fifo_q[1].size() +
                                fifo_q[2].size() + fifo_q[3].size() > 0); k++) tick();
    tick();
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL random_drain: got pending=%0d v=%b want 0/0", exp_q.size(), out_valid);
    else passed++;
    check_counters("random");
  endtask

  initial begin
    rst = 1'b1; en = '1; out_ready = 1'b0; in_valid = '0; in_data = '0;
    passed = 0; total = 0; cyc = 0; drops_model = 0; stall_pend = 1'b0; acc_src = -1;
    @(negedge clk);
    test_reset();
    test_single_module();
    test_round_robin();
    test_backpressure();
    test_disabled_drain();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
